time_date_counter: RTL and testbench

Time-of-day and calendar keeper feeding the character LCD display controller. Holds the current time (24 h) and date (2000–2099) as BCD digit pairs, advances them once per second from an internal prescaler, and applies user single-step edits in the current-time control modes. Presents every digit as an 8-bit ASCII character ready for direct placement in the display buffer.

---
 rtl/clock_pkg.sv | 44 ++++
 rtl/time_date_counter_if.sv | 18 +
 rtl/sec_prescaler.sv | 24 ++
 rtl/time_date_counter.sv | 108 ++++++++++
 tb/tb_time_date_counter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared clock definitions: mode codes used by the display, alarm and time blocks,
// plus BCD helpers for the calendar.
package clock_pkg;

  localparam logic [5:0] CURRENT_TIME = 6'b000000;
  localparam logic [5:0] CTRL_HOUR    = 6'b010011;
  localparam logic [5:0] CTRL_MIN     = 6'b010101;
  localparam logic [5:0] CTRL_SEC     = 6'b010111;
  localparam logic [5:0] CTRL_YEAR    = 6'b011011;
  localparam logic [5:0] CTRL_MONTH   = 6'b011101;
  localparam logic [5:0] CTRL_DAY     = 6'b011111;

  localparam logic [7:0] ASCII_ZERO = 8'h30;

  function automatic logic is_ctrl_mode(input logic [5:0] mode);
    return (mode == CTRL_HOUR) || (mode == CTRL_MIN) || (mode == CTRL_SEC) ||
           (mode == CTRL_YEAR) || (mode == CTRL_MONTH) || (mode == CTRL_DAY);
  endfunction

  // Callers detect the wrap value themselves, so only the 9->0 digit carry is handled here.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Year mod 4 on a BCD pair: (2*tens + units) mod 4, i.e. odd tens pair with units 2/6.
  function automatic logic [7:0] days_in_month(input logic [7:0] month_bcd,
                                               input logic [7:0] year_bcd);
    logic       leap;
    logic [7:0] dim;
    if (year_bcd[4]) leap = (year_bcd[3:0] == 4'd2) || (year_bcd[3:0] == 4'd6);
    else             leap = (year_bcd[3:0] == 4'd0) || (year_bcd[3:0] == 4'd4) ||
                            (year_bcd[3:0] == 4'd8);
    case (month_bcd)
      8'h02:                      dim = leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: dim = 8'h30;
      default:                    dim = 8'h31;
    endcase
    return dim;
  endfunction

endpackage

// File: rtl/time_date_counter_if.sv
// Mode/edit inputs and ASCII digit outputs between the time keeper and its users.
interface time_date_counter_if;
  logic [5:0] MODE;
  logic       INC_PULSE;
  logic [7:0] H10, H1, M10, M1, S10, S1;
  logic [7:0] Y10, Y1, MT10, MT1, D10, D1;
  logic       SEC_PULSE;

  modport master (
    output MODE, INC_PULSE,
    input  H10, H1, M10, M1, S10, S1, Y10, Y1, MT10, MT1, D10, D1, SEC_PULSE
  );

  modport slave (
    input  MODE, INC_PULSE,
    output H10, H1, M10, M1, S10, S1, Y10, Y1, MT10, MT1, D10, D1, SEC_PULSE
  );
endinterface

// File: rtl/sec_prescaler.sv
// Divides CLK down to a one-cycle TICK per second; HOLD parks the count at zero.
module sec_prescaler #(
  parameter int CLK_HZ = 50000
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic HOLD,
  output logic TICK
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] count;

  assign TICK = !HOLD && (count == TERM);

  always_ff @(posedge CLK) begin
    if (!RESETN || HOLD) count <= '0;
    else if (count == TERM) count <= '0;
    else count <= count + 1'b1;
  end

endmodule

// File: rtl/time_date_counter.sv
// 24 h time and 2000-2099 calendar in BCD, advanced by the second tick or by
// single-step edits, presented as ASCII digits.
module time_date_counter
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 50000
) (
  input logic                 CLK,
  input logic                 RESETN,
  time_date_counter_if.slave  bus
);

  logic [7:0] hour, minute, second, year, month, day;
  logic [7:0] nxt_hour, nxt_minute, nxt_second, nxt_year, nxt_month, nxt_day;
  logic [7:0] dim_cur, dim_new;
  logic       ctrl_mode, tick, sec_pulse;

  assign ctrl_mode = is_ctrl_mode(bus.MODE);
  assign dim_cur   = days_in_month(month, year);
  assign dim_new   = days_in_month(nxt_month, nxt_year);

  sec_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
    .CLK    (CLK),
    .RESETN (RESETN),
    .HOLD   (ctrl_mode),
    .TICK   (tick)
  );

  // Edits touch one field with no carry; ticks ripple sec->year within one edge.
  always_comb begin
    nxt_hour   = hour;
    nxt_minute = minute;
    nxt_second = second;
    nxt_year   = year;
    nxt_month  = month;
    nxt_day    = day;
    if (ctrl_mode && bus.INC_PULSE) begin
      case (bus.MODE)
        CTRL_HOUR:  nxt_hour   = (hour   == 8'h23) ? 8'h00 : bcd_inc(hour);
        CTRL_MIN:   nxt_minute = (minute == 8'h59) ? 8'h00 : bcd_inc(minute);
        CTRL_SEC:   nxt_second = (second == 8'h59) ? 8'h00 : bcd_inc(second);
        CTRL_YEAR:  nxt_year   = (year   == 8'h99) ? 8'h00 : bcd_inc(year);
        CTRL_MONTH: nxt_month  = (month  == 8'h12) ? 8'h01 : bcd_inc(month);
        CTRL_DAY:   nxt_day    = (day    == dim_cur) ? 8'h01 : bcd_inc(day);
        default:    ;
      endcase
      if ((bus.MODE == CTRL_MONTH || bus.MODE == CTRL_YEAR) && (day > dim_new))
        nxt_day = dim_new;
    end else if (tick) begin
      if (second != 8'h59) nxt_second = bcd_inc(second);
      else begin
        nxt_second = 8'h00;
        if (minute != 8'h59) nxt_minute = bcd_inc(minute);
        else begin
          nxt_minute = 8'h00;
          if (hour != 8'h23) nxt_hour = bcd_inc(hour);
          else begin
            nxt_hour = 8'h00;
            if (day != dim_cur) nxt_day = bcd_inc(day);
            else begin
              nxt_day = 8'h01;
              if (month != 8'h12) nxt_month = bcd_inc(month);
              else begin
                nxt_month = 8'h01;
                nxt_year  = (year == 8'h99) ? 8'h00 : bcd_inc(year);
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      hour      <= 8'h00;
      minute    <= 8'h00;
      second    <= 8'h00;
      year      <= 8'h00;
      month     <= 8'h01;
      day       <= 8'h01;
      sec_pulse <= 1'b0;
    end else begin
      hour      <= nxt_hour;
      minute    <= nxt_minute;
      second    <= nxt_second;
      year      <= nxt_year;
      month     <= nxt_month;
      day       <= nxt_day;
      sec_pulse <= tick;
    end
  end

  assign bus.H10  = {ASCII_ZERO[7:4], hour[7:4]};
  assign bus.H1   = {ASCII_ZERO[7:4], hour[3:0]};
  assign bus.M10  = {ASCII_ZERO[7:4], minute[7:4]};
  assign bus.M1   = {ASCII_ZERO[7:4], minute[3:0]};
  assign bus.S10  = {ASCII_ZERO[7:4], second[7:4]};
  assign bus.S1   = {ASCII_ZERO[7:4], second[3:0]};
  assign bus.Y10  = {ASCII_ZERO[7:4], year[7:4]};
  assign bus.Y1   = {ASCII_ZERO[7:4], year[3:0]};
  assign bus.MT10 = {ASCII_ZERO[7:4], month[7:4]};
  assign bus.MT1  = {ASCII_ZERO[7:4], month[3:0]};
  assign bus.D10  = {ASCII_ZERO[7:4], day[7:4]};
  assign bus.D1   = {ASCII_ZERO[7:4], day[3:0]};
  assign bus.SEC_PULSE = sec_pulse;

endmodule

// File: tb/tb_time_date_counter.sv
// Directed bench for time_date_counter at CLK_HZ=4: expected snapshots are queued
// when each step is driven and popped when the DUT outputs are compared.
module tb_time_date_counter;
  import clock_pkg::*;

  localparam int HZ = 4;

  typedef struct {
    string       tag;
    logic [95:0] chars;
  } snap_t;

  logic clk = 1'b0;
  logic resetn;
  int   cmp_cnt  = 0;
  int   fail_cnt = 0;
  snap_t exp_q[$];

  time_date_counter_if bus ();

  time_date_counter #(.CLK_HZ(HZ)) dut (
    .CLK    (clk),
    .RESETN (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ascii_pair(input logic [7:0] bcd);
    return {4'h3, bcd[7:4], 4'h3, bcd[3:0]};
  endfunction

  function automatic logic [95:0] dut_chars();
    return {bus.H10, bus.H1, bus.M10, bus.M1, bus.S10, bus.S1,
            bus.Y10, bus.Y1, bus.MT10, bus.MT1, bus.D10, bus.D1};
  endfunction

  task automatic push_exp(input string tag, input logic [7:0] h, m, s, y, mt, d);
    snap_t e;
    e.tag   = tag;
    e.chars = {ascii_pair(h), ascii_pair(m), ascii_pair(s),
               ascii_pair(y), ascii_pair(mt), ascii_pair(d)};
    exp_q.push_back(e);
  endtask

  task automatic check_val(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    snap_t e;
    if (exp_q.size() == 0) begin
      cmp_cnt++;
      fail_cnt++;
      $display("[TB] FAIL scoreboard: observed empty queue expected entry");
    end else begin
      e = exp_q.pop_front();
      check_val(e.tag, dut_chars(), e.chars);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [5:0] mode, input int n);
    bus.MODE      = mode;
    bus.INC_PULSE = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    bus.INC_PULSE = 1'b0;
  endtask

  // Returns to a run mode and expects the first pulse exactly HZ edges later.
  task automatic tick_from_hold(input string tag);
    bus.MODE = CURRENT_TIME;
    for (int i = 1; i <= HZ; i++) begin
      run(1);
      check_val($sformatf("%s_pulse%0d", tag, i), 96'(bus.SEC_PULSE), 96'(i == HZ));
    end
  endtask

  task automatic set_hms_max();
    apply_stimulus(CTRL_HOUR, 23);
    apply_stimulus(CTRL_MIN, 59);
    apply_stimulus(CTRL_SEC, 59);
  endtask

  initial begin
    int pulses;
    resetn        = 1'b0;
    bus.MODE      = CURRENT_TIME;
    bus.INC_PULSE = 1'b0;
    @(negedge clk);
    push_exp("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01);
    run(2);
    check_output();
    check_val("reset_pulse", 96'(bus.SEC_PULSE), 96'(0));
    resetn = 1'b1;

    push_exp("run16", 8'h00, 8'h00, 8'h04, 8'h00, 8'h01, 8'h01);
    pulses = 0;
    for (int i = 1; i <= 16; i++) begin
      run(1);
      if (bus.SEC_PULSE === 1'b1) pulses++;
      check_val($sformatf("run16_pulse%0d", i), 96'(bus.SEC_PULSE), 96'((i % HZ) == 0));
    end
    check_val("run16_count", 96'(pulses), 96'(4));
    check_output();

    $display("[TB] new year rollover");
    apply_stimulus(CTRL_SEC, 55);
    apply_stimulus(CTRL_MIN, 59);
    apply_stimulus(CTRL_HOUR, 23);
    apply_stimulus(CTRL_YEAR, 99);
    apply_stimulus(CTRL_MONTH, 11);
    apply_stimulus(CTRL_DAY, 30);
    push_exp("preload", 8'h23, 8'h59, 8'h59, 8'h99, 8'h12, 8'h31);
    check_output();
    push_exp("pre_tick", 8'h23, 8'h59, 8'h59, 8'h99, 8'h12, 8'h31);
    push_exp("newyear", 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01);
    bus.MODE = CURRENT_TIME;
    run(HZ - 1);
    check_output();
    check_val("pre_tick_pulse", 96'(bus.SEC_PULSE), 96'(0));
    run(1);
    check_output();
    check_val("newyear_pulse", 96'(bus.SEC_PULSE), 96'(1));

    $display("[TB] february rollover");
    apply_stimulus(CTRL_YEAR, 3);
    apply_stimulus(CTRL_MONTH, 1);
    apply_stimulus(CTRL_DAY, 27);
    set_hms_max();
    push_exp("feb28_y03", 8'h00, 8'h00, 8'h00, 8'h03, 8'h03, 8'h01);
    tick_from_hold("feb28_y03");
    check_output();

    apply_stimulus(CTRL_YEAR, 1);
    apply_stimulus(CTRL_MONTH, 11);
    apply_stimulus(CTRL_DAY, 27);
    set_hms_max();
    push_exp("feb28_y04", 8'h00, 8'h00, 8'h00, 8'h04, 8'h02, 8'h29);
    tick_from_hold("feb28_y04");
    check_output();
    set_hms_max();
    push_exp("feb29_y04", 8'h00, 8'h00, 8'h00, 8'h04, 8'h03, 8'h01);
    tick_from_hold("feb29_y04");
    check_output();

    $display("[TB] month edit clamp");
    apply_stimulus(CTRL_YEAR, 97);
    apply_stimulus(CTRL_MONTH, 10);
    apply_stimulus(CTRL_DAY, 30);
    push_exp("jan31_y01", 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h31);
    check_output();
    push_exp("clamp", 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h28);
    apply_stimulus(CTRL_MONTH, 1);
    check_output();
    check_val("clamp_day_ascii", 96'({bus.D10, bus.D1}), 96'(16'h3238));
    push_exp("day_wrap", 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h01);
    apply_stimulus(CTRL_DAY, 1);
    check_output();

    $display("[TB] second edit and hold");
    apply_stimulus(CTRL_MIN, 7);
    push_exp("sec_wrap", 8'h00, 8'h07, 8'h00, 8'h01, 8'h02, 8'h01);
    apply_stimulus(CTRL_SEC, 60);
    check_output();
    push_exp("hold", 8'h00, 8'h07, 8'h00, 8'h01, 8'h02, 8'h01);
    pulses = 0;
    for (int i = 0; i < 3 * HZ; i++) begin
      run(1);
      if (bus.SEC_PULSE !== 1'b0) pulses++;
    end
    check_val("hold_pulses", 96'(pulses), 96'(0));
    check_output();
    push_exp("release", 8'h00, 8'h07, 8'h01, 8'h01, 8'h02, 8'h01);
    tick_from_hold("release");
    check_output();

    $display("[TB] increments ignored in run modes");
    push_exp("run_inc", 8'h00, 8'h07, 8'h02, 8'h01, 8'h02, 8'h01);
    apply_stimulus(CURRENT_TIME, HZ);
    check_output();
    push_exp("other_inc", 8'h00, 8'h07, 8'h03, 8'h01, 8'h02, 8'h01);
    apply_stimulus(6'b100111, HZ);
    check_output();

    $display("[TB] reset mid-count");
    bus.MODE = CURRENT_TIME;
    run(2);
    resetn = 1'b0;
    push_exp("mid_reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01);
    run(1);
    check_output();
    check_val("mid_reset_pulse", 96'(bus.SEC_PULSE), 96'(0));
    resetn = 1'b1;
    push_exp("post_reset", 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h01);
    tick_from_hold("post_reset");
    check_output();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
